// File: rtl/mem_access_ctrl.sv
// Request sequencer for a single-port synchronous memory with a 1-cycle read.
// Accepts read/write requests and returns read data through a 2-entry response
// FIFO. A clear engine sweeps every address with a fill value.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    // One extra bit so a sweep of 2^ADDR_WIDTH words still has a distinct last count.
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      clr_cnt;
    logic                  clr_done_q;
    logic                  rd_pending;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  accept;
    logic                  rd_accept;
    logic                  push;
    logic                  pop;

    // Handshake qualifiers; outputs are forced low while reset is held.
    assign req_ready = !rst && (state == IDLE) && !clr_start
                       && ((3'(fifo_count) + 3'(rd_pending)) < 3'd2);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign push      = rd_pending;
    assign rsp_valid = !rst && (fifo_count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];
    assign busy      = !rst && (state != IDLE);
    assign clr_done  = !rst && clr_done_q;

    // Memory drive: request pass-through, overridden by the sweep during CLEAR.
    always_comb begin
        mem_addr    = req_addr;
        mem_data_in = req_wdata;
        mem_we      = accept && req_we;
        if (state == CLEAR) begin
            mem_addr    = clr_cnt[ADDR_WIDTH-1:0];
            mem_data_in = clr_value;
            mem_we      = !rst;
        end
    end

    // Control FSM with sweep counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= rd_pending ? DRAIN : CLEAR;
                    end
                end
                DRAIN: begin
                    state <= CLEAR;
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= IDLE;
                        clr_cnt    <= '0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read-in-flight flag and response FIFO pointers/occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            rd_pending <= rd_accept;
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; captures the memory output the cycle after a read is accepted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data_out;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: behavioural memory, reference memory image
// and a queue of expected read responses.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       clr_start;
    logic [7:0] clr_value;
    logic       busy;
    logic       clr_done;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_we;
    logic [7:0] mem_data_out;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_q   [$];

    int vectors     = 0;
    int miscompares = 0;
    int n_rsp       = 0;
    logic ovf_seen  = 1'b0;

    mem_access_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .MEM_DEPTH (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .clr_start   (clr_start),
        .clr_value   (clr_value),
        .busy        (busy),
        .clr_done    (clr_done),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_we      (mem_we),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory with registered read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push expected data on read acceptance, compare on response pop.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
                    n_rsp++;
                end
            end
            if (req_valid && req_ready && !req_we) exp_q.push_back(ref_mem[req_addr]);
            if (dut.rd_pending && dut.fifo_count == 2'd2) ovf_seen = 1'b1;
        end
    end

    // Issue one request and hold it until accepted (bounded).
    task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        #1;
        while (!req_ready && n < 600) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (we) ref_mem[a] = d;
    endtask

    // Wait until every expected response has been consumed (bounded).
    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int busy_cnt;
        int we_cnt;
        int done_cnt;
        int bad;
        int rsp0;
        int n;

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_wdata = 8'hFF;
        rsp_ready = 1'b1; clr_start = 1'b1; clr_value = 8'h00;

        // Reset: outputs held low regardless of inputs.
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_clr_done",  32'(clr_done),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; clr_start = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy",  32'(busy),      32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Test 1: write then read same address next cycle.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h5A;
        #1;
        check("t1_wr_ready", 32'(req_ready), 32'd1);
        check("t1_mem_we",   32'(mem_we),    32'd1);
        check("t1_mem_addr", 32'(mem_addr),  32'h10);
        @(posedge clk); #1;
        ref_mem[8'h10] = 8'h5A;
        req_we = 1'b0;
        #1;
        check("t1_rd_ready",  32'(req_ready), 32'd1);
        check("t1_mem_we_rd", 32'(mem_we),    32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        check("t1_lat1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2;
        check("t1_lat2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_rdata",      32'(rsp_rdata), 32'h5A);
        drain("t1_drain");

        // Test 2: credit limit with stalled consumer, then ordered drain.
        issue(1'b1, 8'h00, 8'h11);
        issue(1'b1, 8'h01, 8'h22);
        issue(1'b1, 8'h02, 8'h33);
        issue(1'b1, 8'h03, 8'h44);
        rsp0 = n_rsp;
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; acc = 0;
        for (int i = 0; i < 6; i++) begin
            logic got;
            #1; got = req_ready;
            @(posedge clk); #1;
            if (got) begin acc++; req_addr = 8'(acc); end
        end
        check("t2_accepted_stalled", 32'(acc), 32'd2);
        #1;
        check("t2_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        n = 0;
        while (acc < 4 && n < 50) begin
            logic got;
            #1; got = req_ready;
            @(posedge clk); #1; n++;
            if (got) begin acc++; req_addr = 8'(acc); end
            if (acc == 4) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("t2_accepted_total", 32'(acc), 32'd4);
        drain("t2_drain");
        check("t2_rsp_count", 32'(n_rsp - rsp0), 32'd4);

        // Test 3: full clear sweep.
        clr_value = 8'hA5; clr_start = 1'b1;
        #1;
        check("t3_ready_on_start", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        clr_start = 1'b0;
        busy_cnt = 0; we_cnt = 0; done_cnt = 0; bad = 0;
        repeat (300) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            we_cnt   += int'(mem_we);
            done_cnt += int'(clr_done);
            bad      += int'(clr_done && busy);
        end
        check("t3_busy_cycles",  32'(busy_cnt), 32'd256);
        check("t3_we_cycles",    32'(we_cnt),   32'd256);
        check("t3_done_pulses",  32'(done_cnt), 32'd1);
        check("t3_done_vs_busy", 32'(bad),      32'd0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'hA5;
        @(posedge clk); #1;
        rsp0 = n_rsp;
        issue(1'b0, 8'h00, 8'h00);
        issue(1'b0, 8'h7F, 8'h00);
        issue(1'b0, 8'hFF, 8'h00);
        drain("t3_drain");
        check("t3_rsp_count", 32'(n_rsp - rsp0), 32'd3);

        // Test 4: clear requested while a read is in flight -> DRAIN.
        issue(1'b1, 8'h20, 8'h3C);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20;
        #1;
        check("t4_rd_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; clr_start = 1'b1; clr_value = 8'h00;
        #1;
        check("t4_busy_pre", 32'(busy), 32'd0);
        @(posedge clk); #1;
        clr_start = 1'b0;
        #1;
        check("t4_drain_busy",   32'(busy),      32'd1);
        check("t4_drain_mem_we", 32'(mem_we),    32'd0);
        check("t4_drain_rsp",    32'(rsp_valid), 32'd1);
        check("t4_drain_rdata",  32'(rsp_rdata), 32'h3C);
        we_cnt = 0; done_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            we_cnt   += int'(mem_we);
            done_cnt += int'(clr_done);
        end
        check("t4_we_cycles",   32'(we_cnt),   32'd256);
        check("t4_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        drain("t4_drain");

        // Test 5: clr_start and write request in the same cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h77;
        clr_value = 8'h77; clr_start = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'hEE;
        #1;
        check("t5_ready", 32'(req_ready), 32'd0);
        check("t5_mem_we", 32'(mem_we),   32'd0);
        @(posedge clk); #1;
        clr_start = 1'b0;
        n = 0;
        while (!req_ready && n < 600) begin
            @(posedge clk); #1; n++;
        end
        check("t5_wait_cycles", 32'(n), 32'd256);
        check("t5_clr_done",    32'(clr_done), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        ref_mem[8'h40] = 8'hEE;
        rsp0 = n_rsp;
        issue(1'b0, 8'h40, 8'h00);
        issue(1'b0, 8'h41, 8'h00);
        drain("t5_drain");
        check("t5_rsp_count", 32'(n_rsp - rsp0), 32'd2);

        // Test 6: reset at sweep cycle 100 with a response held in the FIFO.
        rsp_ready = 1'b0;
        issue(1'b0, 8'h10, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        check("t6_fifo_held", 32'(rsp_valid), 32'd1);
        clr_value = 8'h99; clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("t6_rst_mem_we", 32'(mem_we),    32'd0);
        check("t6_rst_busy",   32'(busy),      32'd0);
        check("t6_rst_rsp",    32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_idle_busy",   32'(busy),      32'd0);
        check("t6_idle_rsp",    32'(rsp_valid), 32'd0);
        check("t6_idle_mem_we", 32'(mem_we),    32'd0);
        done_cnt = 0; busy_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            done_cnt += int'(clr_done);
            busy_cnt += int'(busy);
        end
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_no_busy", 32'(busy_cnt), 32'd0);
        for (int i = 0; i < 100; i++) ref_mem[i] = 8'h99;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp0 = n_rsp;
        issue(1'b0, 8'h63, 8'h00);
        issue(1'b0, 8'h64, 8'h00);
        issue(1'b0, 8'h00, 8'h00);
        drain("t6_drain");
        check("t6_rsp_count", 32'(n_rsp - rsp0), 32'd3);

        check("fifo_overflow", 32'(ovf_seen), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
